// File: rtl/rs232_tx.sv
// rtl/rs232_tx.sv - UART transmitter, 8 data bits LSB first, optional even parity, 1 or 2 stop bits
// Bit timing from a phase accumulator ticking once per bit period.
module rs232_tx #(
  parameter int CLOCK_FREQ     = 100000000,
  parameter int BAUD_RATE      = 115200,
  parameter int BAUD_ACC_WIDTH = 16,
  parameter int PARITY_EN      = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic       clock,
  input  logic       reset_neg,
  input  logic       Exe_LogicImp,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_line
);

  localparam int W = BAUD_ACC_WIDTH;
  localparam logic [63:0] INCR_CALC =
    ((64'(BAUD_RATE) << (W - 4)) + (64'(CLOCK_FREQ) >> 5)) / (64'(CLOCK_FREQ) >> 4);
  localparam logic [W:0] INCR = INCR_CALC[W:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  state_t     state, state_next;
  logic [W:0] acc, acc_next, acc_sum;
  logic [7:0] shift_reg, shift_next;
  logic [2:0] bit_cnt, cnt_next;
  logic       parity_bit, parity_next;
  logic       line_next, done_next;
  logic       tick;

  assign acc_sum = {1'b0, acc[W-1:0]} + INCR;
  assign tick    = acc[W];
  assign tx_busy = (state != S_IDLE);

  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      state      <= S_IDLE;
      acc        <= '0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
      tx_line    <= 1'b1;
      tx_done    <= 1'b0;
    end else if (Exe_LogicImp) begin
      state      <= S_IDLE;
      acc        <= '0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
      tx_line    <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_next;
      acc        <= acc_next;
      shift_reg  <= shift_next;
      bit_cnt    <= cnt_next;
      parity_bit <= parity_next;
      tx_line    <= line_next;
      tx_done    <= done_next;
    end
  end

  // The accumulator starts counting on the accept edge so START lasts one full interval.
  always_comb begin
    state_next  = state;
    acc_next    = acc_sum;
    shift_next  = shift_reg;
    cnt_next    = bit_cnt;
    parity_next = parity_bit;
    line_next   = tx_line;
    done_next   = 1'b0;
    case (state)
      S_IDLE: begin
        acc_next  = '0;
        line_next = 1'b1;
        // tx_done high means this is the frame-end cycle; the request waits one cycle.
        if (tx_start && !tx_done) begin
          state_next  = S_START;
          acc_next    = INCR;
          shift_next  = tx_data;
          parity_next = ^tx_data;
          line_next   = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          state_next = S_DATA;
          line_next  = shift_reg[0];
          shift_next = {1'b0, shift_reg[7:1]};
          cnt_next   = 3'd0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_cnt == 3'd7) begin
            if (PARITY_EN == 1) begin
              state_next = S_PARITY;
              line_next  = parity_bit;
            end else begin
              state_next = S_STOP1;
              line_next  = 1'b1;
            end
          end else begin
            line_next  = shift_reg[0];
            shift_next = {1'b0, shift_reg[7:1]};
            cnt_next   = bit_cnt + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_next = S_STOP1;
          line_next  = 1'b1;
        end
      end
      S_STOP1: begin
        if (tick) begin
          line_next = 1'b1;
          if (STOP_BITS == 2) begin
            state_next = S_STOP2;
          end else begin
            state_next = S_IDLE;
            acc_next   = '0;
            done_next  = 1'b1;
          end
        end
      end
      S_STOP2: begin
        if (tick) begin
          state_next = S_IDLE;
          acc_next   = '0;
          line_next  = 1'b1;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        acc_next   = '0;
        line_next  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_rs232_tx.sv
// tb/tb_rs232_tx.sv - self-checking bench for rs232_tx
// Two instances: 8N1 and 8E2; the 8N1 line also feeds a behavioural receiver.
module tb_rs232_tx;

  localparam int CF  = 1600000;
  localparam int BR  = 100000;
  localparam int BIT = 16;

  logic       clk = 1'b0;
  logic       reset_neg, clear;
  logic       start0, start1;
  logic [7:0] data0, data1;
  logic       busy0, done0, line0;
  logic       busy1, done1, line1;

  int n_cmp = 0;
  int n_err = 0;
  int rx_ferr = 0;
  logic [7:0] rx_q[$];
  logic [7:0] sent0[$];

  always #5 clk = ~clk;

  rs232_tx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .BAUD_ACC_WIDTH(16), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
    .clock(clk), .reset_neg(reset_neg), .Exe_LogicImp(clear), .tx_start(start0), .tx_data(data0),
    .tx_busy(busy0), .tx_done(done0), .tx_line(line0));

  rs232_tx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .BAUD_ACC_WIDTH(16), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
    .clock(clk), .reset_neg(reset_neg), .Exe_LogicImp(clear), .tx_start(start1), .tx_data(data1),
    .tx_busy(busy1), .tx_done(done1), .tx_line(line1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin
      start0 = v;
      data0  = d;
    end else begin
      start1 = v;
      data1  = d;
    end
  endtask

  function automatic logic line_of(input int sel);
    return (sel == 0) ? line0 : line1;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 0) ? done0 : done1;
  endfunction

  // Caller is at a negedge with the selected transmitter idle.
  task automatic frame(input int sel, input logic [7:0] d, input int ign_at,
                       input bit start_at_done, input int clear_at);
    logic bits[12];
    int   nb;
    int   ones;
    string nm;
    nm   = (sel == 0) ? "8N1" : "8E2";
    ones = 0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bits[i+1] = d[i];
      ones += int'(d[i]);
    end
    if (sel == 1) begin
      bits[9]  = (ones % 2) != 0;
      bits[10] = 1'b1;
      bits[11] = 1'b1;
      nb = 12;
    end else begin
      bits[9] = 1'b1;
      nb = 10;
    end
    set_start(sel, 1'b1, d);
    @(negedge clk);
    set_start(sel, 1'b0, 8'($urandom));
    for (int j = 0; j < nb * BIT; j++) begin
      check($sformatf("%s d=%02h line bit%0d cyc%0d", nm, d, j / BIT, j), 32'(line_of(sel)), 32'(bits[j / BIT]));
      check($sformatf("%s busy cyc%0d", nm, j), 32'(busy_of(sel)), 32'd1);
      check($sformatf("%s done cyc%0d", nm, j), 32'(done_of(sel)), 32'd0);
      if (j == clear_at) begin
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check($sformatf("%s clear line", nm), 32'(line_of(sel)), 32'd1);
        check($sformatf("%s clear busy", nm), 32'(busy_of(sel)), 32'd0);
        for (int k = 0; k < 3 * BIT; k++) begin
          check($sformatf("%s clear done cyc%0d", nm, k), 32'(done_of(sel)), 32'd0);
          check($sformatf("%s clear idle line cyc%0d", nm, k), 32'(line_of(sel)), 32'd1);
          @(negedge clk);
        end
        return;
      end
      if (j == ign_at) set_start(sel, 1'b1, 8'hFF);
      else if (j == ign_at + 1) set_start(sel, 1'b0, 8'($urandom));
      @(negedge clk);
    end
    check($sformatf("%s end busy", nm), 32'(busy_of(sel)), 32'd0);
    check($sformatf("%s end done", nm), 32'(done_of(sel)), 32'd1);
    check($sformatf("%s end line", nm), 32'(line_of(sel)), 32'd1);
    if (sel == 0) sent0.push_back(d);
    if (start_at_done) set_start(sel, 1'b1, 8'($urandom));
    @(negedge clk);
    check($sformatf("%s post busy", nm), 32'(busy_of(sel)), 32'd0);
    check($sformatf("%s post done", nm), 32'(done_of(sel)), 32'd0);
    check($sformatf("%s post line", nm), 32'(line_of(sel)), 32'd1);
  endtask

  // Receiver: find the start edge, then sample mid-bit every bit period.
  initial begin
    logic [7:0] rx_byte;
    forever begin
      @(negedge clk);
      if (reset_neg === 1'b1 && line0 === 1'b0) begin
        repeat (7) @(negedge clk);
        if (line0 !== 1'b0) rx_ferr++;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          rx_byte[i] = line0;
        end
        repeat (BIT) @(negedge clk);
        if (line0 !== 1'b1) rx_ferr++;
        else rx_q.push_back(rx_byte);
      end
    end
  end

  initial begin
    reset_neg = 1'b0;
    clear     = 1'b0;
    start0    = 1'b1;
    start1    = 1'b1;
    data0     = 8'h5A;
    data1     = 8'hC3;
    repeat (4) @(negedge clk);
    check("reset line0", 32'(line0), 32'd1);
    check("reset busy0", 32'(busy0), 32'd0);
    check("reset done0", 32'(done0), 32'd0);
    check("reset line1", 32'(line1), 32'd1);
    check("reset busy1", 32'(busy1), 32'd0);
    check("reset done1", 32'(done1), 32'd0);
    start0    = 1'b0;
    start1    = 1'b0;
    reset_neg = 1'b1;
    for (int k = 0; k < 2 * BIT; k++) begin
      @(negedge clk);
      check("after reset line0", 32'(line0), 32'd1);
      check("after reset busy0", 32'(busy0), 32'd0);
      check("after reset line1", 32'(line1), 32'd1);
    end

    frame(0, 8'hA5, -1, 1'b0, -1);
    frame(1, 8'h07, -1, 1'b0, -1);

    frame(0, 8'($urandom), 40, 1'b1, -1);
    frame(0, 8'($urandom), -1, 1'b0, -1);

    frame(1, 8'($urandom), -1, 1'b0, 4 * BIT + 5);
    frame(1, 8'($urandom), -1, 1'b0, -1);

    for (int k = 0; k < 6; k++)
      frame(int'($urandom_range(0, 1)), 8'($urandom), -1, 1'b0, -1);

    frame(0, 8'h00, -1, 1'b1, -1);
    frame(0, 8'h55, -1, 1'b1, -1);
    frame(0, 8'hFF, -1, 1'b1, -1);
    frame(0, 8'h3C, -1, 1'b0, -1);
    repeat (4) @(negedge clk);

    check("rx framing errors", 32'(rx_ferr), 32'd0);
    check("rx byte count", 32'(rx_q.size()), 32'(sent0.size()));
    for (int i = 0; i < sent0.size(); i++)
      if (i < rx_q.size()) check($sformatf("rx byte %0d", i), 32'(rx_q[i]), 32'(sent0[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
